// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the GPR-file write arbiter.
package rf_arb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // One queued B-side write; valid drops when the entry is popped or killed.
    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] pc;
    } rf_entry_t;

    // One-hot register mask used by the hazard unit.
    function automatic logic [(1<<REG_W)-1:0] reg_onehot(input logic [REG_W-1:0] r);
        reg_onehot = {{((1<<REG_W)-1){1'b0}}, 1'b1} << r;
    endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// DEPTH-entry FIFO for B-side results with kill-by-address and a pending-write mask.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  rf_entry_t               push_entry_i,
    input  logic                    pop_i,
    input  logic                    kill_en_i,
    input  logic [REG_W-1:0]        kill_addr_i,
    output rf_entry_t               head_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [(1<<REG_W)-1:0]   pend_mask_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic                vld_q  [DEPTH];
    logic [REG_W-1:0]    addr_q [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [DATA_W-1:0]   pc_q   [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W:0]      count_q;
    logic [PTR_W:0]      count_d;

    // Occupancy bookkeeping: count follows push/pop, pointers wrap naturally.
    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (pop_i && !push_i) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control state: pointers, count and per-slot valid (kill, pop, push in that priority order).
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en_i && vld_q[i] && (addr_q[i] == kill_addr_i)) begin
                    vld_q[i] <= 1'b0;
                end
            end
            if (pop_i) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + 1'b1;
            end
            // A push only lands in a free slot, so it never collides with the pop/kill above.
            if (push_i) begin
                vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by vld_q.
    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[wr_ptr_q] <= push_entry_i.addr;
            data_q[wr_ptr_q] <= push_entry_i.data;
            pc_q[wr_ptr_q]   <= push_entry_i.pc;
        end
    end

    // Head view and pending mask over all still-valid slots.
    always_comb begin
        head_o.valid = vld_q[rd_ptr_q];
        head_o.addr  = addr_q[rd_ptr_q];
        head_o.data  = data_q[rd_ptr_q];
        head_o.pc    = pc_q[rd_ptr_q];
        pend_mask_o  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                pend_mask_o = pend_mask_o | reg_onehot(addr_q[i]);
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single RF write port between the W stage (A, always wins) and a queued
// multi-cycle unit (B), with starvation-driven pipeline stall and WAW kill of stale B writes.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               a_we,
    input  logic [REG_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]  a_data,
    input  logic [DATA_W-1:0]  a_pc,
    input  logic               b_valid,
    output logic               b_ready,
    input  logic [REG_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]  b_data,
    input  logic [DATA_W-1:0]  b_pc,
    output logic               rf_we,
    output logic [REG_W-1:0]   rf_addr,
    output logic [DATA_W-1:0]  rf_data,
    output logic [DATA_W-1:0]  rf_pc,
    output logic [31:0]        pend_mask,
    output logic               pipe_stall
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [SW-1:0]    LIMIT_CNT = SW'(STARVE_LIMIT);

    rf_entry_t          push_entry;
    rf_entry_t          head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_nonempty;
    logic               head_live;
    logic               a_grant;
    logic               b_grant;
    logic               push;
    logic               pop;
    logic [SW-1:0]      starve_q;
    logic [SW-1:0]      starve_d;
    logic               stall_q;
    logic               stall_d;

    // b_ready looks only at registered occupancy; $0 results are accepted but not stored.
    always_comb begin
        b_ready          = !reset && (fifo_count < DEPTH_CNT);
        push             = b_valid && b_ready && (b_addr != REG_ZERO);
        push_entry.valid = 1'b1;
        push_entry.addr  = b_addr;
        push_entry.data  = b_data;
        push_entry.pc    = b_pc;
    end

    // Grant: A first (writes to $0 don't count), else a live FIFO head; killed heads are
    // discarded without using the port.
    always_comb begin
        fifo_nonempty = (fifo_count != '0);
        head_live     = fifo_nonempty && head.valid;
        a_grant       = a_we && (a_addr != REG_ZERO);
        b_grant       = !a_grant && head_live;
        pop           = !reset && (b_grant || (fifo_nonempty && !head.valid));
        rf_we         = 1'b0;
        rf_addr       = '0;
        rf_data       = '0;
        rf_pc         = '0;
        if (!reset) begin
            if (a_grant) begin
                rf_we   = 1'b1;
                rf_addr = a_addr;
                rf_data = a_data;
                rf_pc   = a_pc;
            end else if (head_live) begin
                rf_we   = 1'b1;
                rf_addr = head.addr;
                rf_data = head.data;
                rf_pc   = head.pc;
            end
        end
    end

    // Starvation counter: counts cycles a live head loses to A, saturating at the limit.
    always_comb begin
        starve_d = '0;
        if (head_live && a_grant) begin
            starve_d = (starve_q >= LIMIT_CNT) ? starve_q : starve_q + 1'b1;
        end
        stall_d = (starve_d >= LIMIT_CNT) && fifo_nonempty;
    end

    // Registered starvation state and stall request.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign pipe_stall = stall_q;

    rf_arb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .kill_en_i    (a_grant),
        .kill_addr_i  (a_addr),
        .head_o       (head),
        .count_o      (fifo_count),
        .pend_mask_o  (pend_mask)
    );

endmodule
